weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5: the header byte that starts a load frame.
REQ-002 The block SHALL have parameter N_BYTES, default 48: the payload bytes per frame, 32 for layer 1 and 16 for layer 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input byte is present.
REQ-006 The block SHALL have port in_data, input, 8 bits: the input byte.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port weight_layer1, output, 256 bits: committed layer-1 weights, 4 neurons x 8 signed 8-bit weights.
REQ-009 The block SHALL have port weight_layer2, output, 128 bits: committed layer-2 weights, 8 words x 2 signed 8-bit weights.
REQ-010 The block SHALL have port weights_valid, output, 1 bit: set once a frame has committed; held until reset.
REQ-011 The block SHALL have port load_done, output, 1 bit: one-cycle pulse on commit.
REQ-012 The block SHALL have port load_err, output, 1 bit: one-cycle pulse on a rejected frame.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 A byte SHALL transfer only in a cycle where in_valid and in_ready are both high.
REQ-015 The FSM SHALL have the states IDLE, LOAD, CHECK and COMMIT.
REQ-016 In IDLE, in_ready SHALL be 1; an accepted byte equal to SYNC_BYTE SHALL go to LOAD with byte count 0; any other byte SHALL be dropped silently.
REQ-017 In LOAD, payload byte k (0..31) SHALL be written to shadow layer-1 bits [255-8k -: 8], most significant byte first.
REQ-018 In LOAD, payload byte k (32..47) SHALL be written to shadow layer-2 bits [127-8(k-32) -: 8].
REQ-019 The byte counter SHALL be 6 bits and SHALL not wrap: acceptance of byte N_BYTES-1 exits LOAD.
REQ-020 In the byte-wise payload, weights SHALL be two's complement and SHALL be stored unmodified, with no sign conversion.
REQ-021 In COMMIT (one cycle), in_ready SHALL be 0, the shadow registers SHALL be copied to weight_layer1/weight_layer2 together, load_done SHALL be 1 and weights_valid SHALL be set; the next state SHALL be IDLE.
REQ-022 The outputs SHALL never show a partially loaded frame: the output registers change only in COMMIT.
REQ-023 In-frame bytes equal to SYNC_BYTE SHALL be treated as data, not as a frame restart.
REQ-024 in_valid low mid-frame SHALL stall the frame with no timeout; the state and count SHALL be held.
REQ-025 A frame after a first commit SHALL overwrite the committed weights only at its own COMMIT; weights_valid SHALL stay 1 throughout.

Reset
REQ-026 While rst is high, the state SHALL be IDLE and the count 0.
REQ-027 While rst is high, the shadow registers, weight_layer1 and weight_layer2 SHALL be 0.
REQ-028 While rst is high, weights_valid, load_done, load_err and busy SHALL be 0, and in_ready SHALL be 0.
REQ-029 On the first cycle after rst falls, in_ready SHALL be 1.
REQ-030 Reset mid-frame SHALL discard the partial frame; no commit and no load_err SHALL result.

Configuration
REQ-031 With macro WEIGHT_CHECKSUM_EN defined, LOAD SHALL go to CHECK after the last payload byte.
REQ-032 In CHECK, in_ready SHALL be 1; the next accepted byte SHALL be compared to the 8-bit modulo-256 sum of the N_BYTES payload bytes, with the sync byte excluded.
REQ-033 On a checksum match, CHECK SHALL go to COMMIT.
REQ-034 On a checksum mismatch, the block SHALL pulse load_err for one cycle, leave the outputs and weights_valid unchanged, and go to IDLE.
REQ-035 Without WEIGHT_CHECKSUM_EN, LOAD SHALL go directly to COMMIT, no CHECK state or sum logic SHALL exist, and load_err SHALL be tied to 0.

Verification
REQ-036 Scenario: reset, then A5 followed by 48 bytes 0x01..0x30 with in_valid held high -> load_done pulses one cycle after byte 48 (without macro); weight_layer1[255:248]=01; weight_layer1[7:0]=20; weight_layer2[127:120]=21; weight_layer2[7:0]=30; weights_valid=1.
REQ-037 Scenario: with the macro, the same frame plus checksum 0x98 -> commit; with checksum 0x97 instead -> load_err pulse, outputs remain 0, weights_valid=0.
REQ-038 Scenario: bytes 00, 7F, then A5 and a frame -> leading bytes ignored, the frame commits normally.
REQ-039 Scenario: a frame with in_valid toggling every other cycle, and a payload containing A5 at k=5 -> correct commit, weight_layer1[215:208]=A5.
REQ-040 Scenario: rst pulsed after 20 payload bytes, then a full new frame -> outputs 0 until the new commit; no load_err.
REQ-041 Scenario: a second frame of all 0xEE after a first commit -> outputs keep the first frame through byte 47 and become all EE at COMMIT; weights_valid stays 1.

Source files
------------

// File: rtl/weight_loader.sv
// weight_loader: byte-stream loader for a two-layer weight set.
// A frame is SYNC_BYTE followed by N_BYTES payload bytes (32 layer-1 bytes,
// then 16 layer-2 bytes, most significant byte first). Payload is gathered
// in shadow registers and copied to the outputs in a single commit cycle,
// so the outputs never expose a partially loaded frame.
// Optional feature: define WEIGHT_CHECKSUM_EN to require a trailing byte equal
// to the modulo-256 sum of the payload; a mismatch drops the frame and pulses
// load_err.
module weight_loader #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned N_BYTES   = 48
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   output logic [255:0] weight_layer1,
   output logic [127:0] weight_layer2,
   output logic         weights_valid,
   output logic         load_done,
   output logic         load_err,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
`ifdef WEIGHT_CHECKSUM_EN
      CHECK  = 2'd2,
`endif
      COMMIT = 2'd3
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [5:0]     count_r;
   logic [5:0]     count_nxt_s;
   logic [255:0]   shadow_l1_r;
   logic [255:0]   shadow_l1_nxt_s;
   logic [127:0]   shadow_l2_r;
   logic [127:0]   shadow_l2_nxt_s;
   logic [7:0]     l1_idx_s;
   logic [6:0]     l2_idx_s;
   logic           accept_s;
   logic           last_byte_s;
   logic           commit_s;
   logic           err_s;
   logic           busy_r;
   logic           load_done_r;
   logic           weights_valid_r;
   logic [255:0]   weight_l1_r;
   logic [127:0]   weight_l2_r;

`ifdef WEIGHT_CHECKSUM_EN
   logic [7:0]     sum_r;
   logic [7:0]     sum_nxt_s;
   logic           load_err_r;

   // Running modulo-256 payload checksum step.
   function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction
`endif

   // Ready whenever out of reset and not in the commit cycle.
   assign in_ready    = ~rst & (state_r != COMMIT);
   assign accept_s    = in_valid & in_ready;
   assign last_byte_s = (count_r == 6'(N_BYTES - 1));
   // Byte k lands at bit 255-8k (layer 1) or 127-8(k-32) (layer 2).
   assign l1_idx_s    = 8'd255 - {count_r[4:0], 3'b000};
   assign l2_idx_s    = 7'd127 - {count_r[3:0], 3'b000};

   assign weight_layer1 = weight_l1_r;
   assign weight_layer2 = weight_l2_r;
   assign weights_valid = weights_valid_r;
   assign load_done     = load_done_r;
   assign busy          = busy_r;
`ifdef WEIGHT_CHECKSUM_EN
   assign load_err      = load_err_r;
`else
   assign load_err      = 1'b0;
`endif

   // Next-state, byte counter, shadow write and checksum accumulation.
   always_comb begin
      state_nxt_s     = state_r;
      count_nxt_s     = count_r;
      shadow_l1_nxt_s = shadow_l1_r;
      shadow_l2_nxt_s = shadow_l2_r;
      err_s           = 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
      sum_nxt_s       = sum_r;
`endif
      case (state_r)
         IDLE: begin
            if (accept_s && (in_data == SYNC_BYTE)) begin
               state_nxt_s = LOAD;
               count_nxt_s = 6'd0;
`ifdef WEIGHT_CHECKSUM_EN
               sum_nxt_s   = 8'd0;
`endif
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            if (accept_s) begin
               // A sync-valued byte here is ordinary payload.
               if (!count_r[5]) begin
                  shadow_l1_nxt_s[l1_idx_s -: 8] = in_data;
               end else if (!count_r[4]) begin
                  shadow_l2_nxt_s[l2_idx_s -: 8] = in_data;
               end else begin
                  shadow_l1_nxt_s = shadow_l1_r;
               end
`ifdef WEIGHT_CHECKSUM_EN
               sum_nxt_s = sum8(sum_r, in_data);
`endif
               if (last_byte_s) begin
                  count_nxt_s = 6'd0;
`ifdef WEIGHT_CHECKSUM_EN
                  state_nxt_s = CHECK;
`else
                  state_nxt_s = COMMIT;
`endif
               end else begin
                  count_nxt_s = count_r + 6'd1;
               end
            end else begin
               state_nxt_s = LOAD;
            end
         end
`ifdef WEIGHT_CHECKSUM_EN
         CHECK: begin
            if (accept_s) begin
               if (in_data == sum_r) begin
                  state_nxt_s = COMMIT;
               end else begin
                  state_nxt_s = IDLE;
                  err_s       = 1'b1;
               end
            end else begin
               state_nxt_s = CHECK;
            end
         end
`endif
         COMMIT: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // The commit cycle is the one entered from LOAD or CHECK.
   assign commit_s = (state_nxt_s == COMMIT) && (state_r != COMMIT);

   // State, shadow and output registers; outputs load only on entry to COMMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         count_r         <= 6'd0;
         shadow_l1_r     <= 256'd0;
         shadow_l2_r     <= 128'd0;
         weight_l1_r     <= 256'd0;
         weight_l2_r     <= 128'd0;
         weights_valid_r <= 1'b0;
         load_done_r     <= 1'b0;
         busy_r          <= 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
         sum_r           <= 8'd0;
         load_err_r      <= 1'b0;
`endif
      end else begin
         state_r     <= state_nxt_s;
         count_r     <= count_nxt_s;
         shadow_l1_r <= shadow_l1_nxt_s;
         shadow_l2_r <= shadow_l2_nxt_s;
         busy_r      <= (state_nxt_s != IDLE);
         load_done_r <= commit_s;
         if (commit_s) begin
            weight_l1_r     <= shadow_l1_nxt_s;
            weight_l2_r     <= shadow_l2_nxt_s;
            weights_valid_r <= 1'b1;
         end else begin
            weights_valid_r <= weights_valid_r;
         end
`ifdef WEIGHT_CHECKSUM_EN
         sum_r      <= sum_nxt_s;
         load_err_r <= err_s;
`endif
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed, table-driven bench for weight_loader.
// Frame recipes live in a table; multi-cycle corners (reset, mid-frame reset,
// bad checksum when WEIGHT_CHECKSUM_EN is defined) are hand-written sequences.
module tb_weight_loader;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = 8'h00;
   logic         in_ready;
   logic [255:0] weight_layer1;
   logic [127:0] weight_layer2;
   logic         weights_valid;
   logic         load_done;
   logic         load_err;
   logic         busy;

   int checks = 0;
   int failures = 0;
   int done_count = 0;
   int err_count = 0;

   logic [7:0]   pay [0:47];
   logic [255:0] exp_l1;
   logic [127:0] exp_l2;
   logic [255:0] prev_l1 = 256'd0;
   logic [127:0] prev_l2 = 128'd0;
   logic         prev_valid = 1'b0;

   typedef struct {
      string      name;
      logic [7:0] base;
      logic [7:0] step;
      bit         junk;
      bit         toggle;
      bit         inj_a5;
      logic [7:0] e_l1_top;
      logic [7:0] e_l1_k5;
      logic [7:0] e_l1_bot;
      logic [7:0] e_l2_top;
      logic [7:0] e_l2_bot;
   } vec_t;

   vec_t vecs [0:3];

   weight_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .weight_layer1(weight_layer1),
      .weight_layer2(weight_layer2), .weights_valid(weights_valid),
      .load_done(load_done), .load_err(load_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Count completion and error pulses.
   always @(posedge clk) begin
      if (!rst && load_done) done_count <= done_count + 1;
      if (!rst && load_err)  err_count  <= err_count + 1;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("ready_timeout", 256'(in_ready), 256'd1);
      @(posedge clk);
   endtask

   task automatic gap();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic gen_payload(input logic [7:0] base, input logic [7:0] step, input bit inj);
      exp_l1 = 256'd0;
      exp_l2 = 128'd0;
      for (int k = 0; k < 48; k++) begin
         pay[k] = base + step * 8'(k);
         if (inj && k == 5) pay[k] = 8'hA5;
         if (k < 32) exp_l1[255 - 8*k -: 8] = pay[k];
         else        exp_l2[127 - 8*(k-32) -: 8] = pay[k];
      end
   endtask

   task automatic hold_check();
      #1;
      chk("hold_l1", weight_layer1, prev_l1);
      chk("hold_l2", 256'(weight_layer2), 256'(prev_l2));
      chk("hold_valid", 256'(weights_valid), 256'(prev_valid));
   endtask

   task automatic send_frame(input bit toggle, input bit good);
      logic [7:0] sum;
      sum = 8'd0;
      send_byte(8'hA5);
      for (int k = 0; k < 48; k++) begin
         if (toggle) gap();
         sum = sum + pay[k];
`ifndef WEIGHT_CHECKSUM_EN
         if (k == 47) hold_check();
`endif
         send_byte(pay[k]);
      end
`ifdef WEIGHT_CHECKSUM_EN
      if (sum != 8'h98 && pay[0] == 8'h01 && pay[47] == 8'h30 && !toggle)
         chk("ramp_sum", 256'(sum), 256'h98);
      hold_check();
      send_byte(good ? sum : (sum - 8'd1));
`else
      if (!good) chk("bad_frame_needs_macro", 256'd0, 256'd1);
`endif
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // In the commit cycle and the one after it.
   task automatic commit_checks(input string name);
      chk({name, "_done"},  256'(load_done), 256'd1);
      chk({name, "_ready"}, 256'(in_ready), 256'd0);
      chk({name, "_busy"},  256'(busy), 256'd1);
      chk({name, "_l1"},    weight_layer1, exp_l1);
      chk({name, "_l2"},    256'(weight_layer2), 256'(exp_l2));
      chk({name, "_valid"}, 256'(weights_valid), 256'd1);
      @(negedge clk);
      chk({name, "_done_low"}, 256'(load_done), 256'd0);
      chk({name, "_idle"},     256'(busy), 256'd0);
      chk({name, "_ready2"},   256'(in_ready), 256'd1);
      prev_l1 = exp_l1;
      prev_l2 = exp_l2;
      prev_valid = 1'b1;
   endtask

   initial begin
      vecs[0] = '{"ramp",      8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 8'h06, 8'h20, 8'h21, 8'h30};
      vecs[1] = '{"junk_lead", 8'h10, 8'h03, 1'b1, 1'b0, 1'b0, 8'h10, 8'h1F, 8'h6D, 8'h70, 8'h9D};
      vecs[2] = '{"toggle_a5", 8'h80, 8'h02, 1'b0, 1'b1, 1'b1, 8'h80, 8'hA5, 8'hBE, 8'hC0, 8'hDE};
      vecs[3] = '{"all_ee",    8'hEE, 8'h00, 1'b0, 1'b0, 1'b0, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_ready", 256'(in_ready), 256'd0);
      chk("rst_busy",  256'(busy), 256'd0);
      chk("rst_valid", 256'(weights_valid), 256'd0);
      chk("rst_done",  256'(load_done), 256'd0);
      chk("rst_err",   256'(load_err), 256'd0);
      chk("rst_l1",    weight_layer1, 256'd0);
      chk("rst_l2",    256'(weight_layer2), 256'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 256'(in_ready), 256'd1);

`ifdef WEIGHT_CHECKSUM_EN
      // Bad checksum: error pulse, outputs untouched.
      gen_payload(8'h01, 8'h01, 1'b0);
      send_frame(1'b0, 1'b0);
      chk("bad_err",   256'(load_err), 256'd1);
      chk("bad_done",  256'(load_done), 256'd0);
      chk("bad_l1",    weight_layer1, 256'd0);
      chk("bad_valid", 256'(weights_valid), 256'd0);
      @(negedge clk);
      chk("bad_err_low", 256'(load_err), 256'd0);
`endif

      // Reset after 20 payload bytes, then a full frame.
      gen_payload(8'h01, 8'h01, 1'b0);
      send_byte(8'hA5);
      for (int k = 0; k < 20; k++) send_byte(pay[k]);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy",  256'(busy), 256'd0);
      chk("midrst_ready", 256'(in_ready), 256'd0);
      chk("midrst_l1",    weight_layer1, 256'd0);
      chk("midrst_err",   256'(load_err), 256'd0);
      rst = 1'b0;
      #1;
      chk("midrst_ready2", 256'(in_ready), 256'd1);
      send_frame(1'b0, 1'b1);
      commit_checks("midrst_frame");

      // Table-driven frames.
      for (int i = 0; i < 4; i++) begin
         gen_payload(vecs[i].base, vecs[i].step, vecs[i].inj_a5);
         if (vecs[i].junk) begin
            send_byte(8'h00);
            send_byte(8'h7F);
            #1;
            chk({vecs[i].name, "_junk_idle"}, 256'(busy), 256'd0);
         end
         send_frame(vecs[i].toggle, 1'b1);
         chk({vecs[i].name, "_l1_top"}, 256'(weight_layer1[255:248]), 256'(vecs[i].e_l1_top));
         chk({vecs[i].name, "_l1_k5"},  256'(weight_layer1[215:208]), 256'(vecs[i].e_l1_k5));
         chk({vecs[i].name, "_l1_bot"}, 256'(weight_layer1[7:0]),     256'(vecs[i].e_l1_bot));
         chk({vecs[i].name, "_l2_top"}, 256'(weight_layer2[127:120]), 256'(vecs[i].e_l2_top));
         chk({vecs[i].name, "_l2_bot"}, 256'(weight_layer2[7:0]),     256'(vecs[i].e_l2_bot));
         commit_checks(vecs[i].name);
      end

      repeat (2) @(negedge clk);
      chk("done_count", 256'(done_count), 256'd5);
`ifdef WEIGHT_CHECKSUM_EN
      chk("err_count", 256'(err_count), 256'd1);
`else
      chk("err_count", 256'(err_count), 256'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog: never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
